dcache_port_arb: RTL and testbench

// - Sequences and arbitrates the single d-cache request port between two requesters:
//   the M-stage access (mem-stage load/store) and the writeback store drain (WB queue head).
// - Sits between the M stage / WB stage and the d-cache request interface.
// - Registers the granted payload and holds it until the cache accepts it.
// - Bounds starvation of either side with saturating wait counters.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/arb_starve_ctr.sv | 16 +
 rtl/dcache_port_arb.sv | 98 +++++++++
 tb/tb_dcache_port_arb.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, access-type codes and default starvation bound for the d-cache port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    BUSY_MEM = 2'b01,
    BUSY_WB  = 2'b10
  } state_e;
  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_RD   = 2'b01;
  localparam logic [1:0] RW_WR   = 2'b10;
  localparam logic [1:0] RW_RMW  = 2'b11;
  localparam logic [3:0] STARVE_MAX_DEF = 4'd6;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: 4-bit wait counter saturating at max; clear wins over inc
module arb_starve_ctr (
  input  logic       clk,
  input  logic       clr,
  input  logic       inc,
  input  logic       clear,
  input  logic [3:0] max,
  output logic [3:0] cnt,
  output logic       sat
);
  assign sat = cnt == max;
  always_ff @(posedge clk or posedge clr)
    if (clr) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (inc && cnt < max) cnt <= cnt + 4'd1;
endmodule

// File: rtl/dcache_port_arb.sv
// dcache_port_arb: arbitrates the single d-cache request port between the M stage and the WB store drain
module dcache_port_arb
  import mem_arb_pkg::*;
#(
  parameter logic [3:0] STARVE_MAX = STARVE_MAX_DEF,
  parameter int         ADDR_W     = 32,
  parameter int         DATA_W     = 64
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_rw,
  input  logic [1:0]        mem_size,
  input  logic [6:0]        mem_ptcid,
  output logic              mem_accept,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [1:0]        wb_size,
  input  logic [6:0]        wb_ptcid,
  input  logic              wb_urgent,
  output logic              wb_accept,
  input  logic              c_ready,
  output logic              c_req_valid,
  output logic              c_req_is_wb,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_data,
  output logic [1:0]        c_rw,
  output logic [1:0]        c_size,
  output logic [6:0]        c_ptcid,
  output logic              mem_stall
);
  state_e              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_rw, r_size;
  logic [6:0]          r_ptcid;
  logic                w_cap, w_mreq, w_both, w_sel_wb;
  logic [1:0]          w_src;
  logic [3:0]          w_wb_cnt, w_mem_cnt;
  logic                w_wb_sat, w_mem_sat;
  assign c_req_valid = r_state != IDLE;
  assign c_req_is_wb = r_state == BUSY_WB;
  assign c_addr      = r_addr;
  assign c_data      = r_data;
  assign c_rw        = r_rw;
  assign c_size      = r_size;
  assign c_ptcid     = r_ptcid;
  assign w_cap  = (r_state == IDLE) | (c_req_valid & c_ready);
  assign w_mreq = mem_valid & |mem_rw;
  assign w_both = w_mreq & wb_valid;
  // a saturated WB counter beats a saturated M counter; urgency only breaks an otherwise even tie
  assign w_sel_wb = w_both ? (w_wb_sat | (~w_mem_sat & wb_urgent)) : wb_valid;
  // src one-hot: [1]=WB, [0]=M; masked during reset so no accept leaks out
  assign w_src = {2{w_cap & ~clr}} & {wb_valid & w_sel_wb, w_mreq & ~w_sel_wb};
  assign mem_accept = w_src[0];
  assign wb_accept  = w_src[1];
  assign mem_stall  = mem_valid & ~mem_accept & ~clr;
  always_comb begin
    w_state_nxt = !w_cap ? r_state : w_src[1] ? BUSY_WB : w_src[0] ? BUSY_MEM : IDLE;
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) r_state <= IDLE;
    else r_state <= w_state_nxt;
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_rw    <= RW_NONE;
      r_size  <= '0;
      r_ptcid <= '0;
    end else if (|w_src) begin
      r_addr  <= w_src[1] ? wb_addr : mem_addr;
      r_data  <= w_src[1] ? wb_data : '0;
      r_rw    <= w_src[1] ? RW_WR : mem_rw;
      r_size  <= w_src[1] ? wb_size : mem_size;
      r_ptcid <= w_src[1] ? wb_ptcid : mem_ptcid;
    end
  arb_starve_ctr u_wb_ctr (
    .clk   (clk),
    .clr   (clr),
    .inc   (w_src[0] & wb_valid),
    .clear (w_src[1] | ~wb_valid),
    .max   (STARVE_MAX),
    .cnt   (w_wb_cnt),
    .sat   (w_wb_sat)
  );
  arb_starve_ctr u_mem_ctr (
    .clk   (clk),
    .clr   (clr),
    .inc   (w_src[1] & w_mreq),
    .clear (w_src[0] | ~w_mreq),
    .max   (STARVE_MAX),
    .cnt   (w_mem_cnt),
    .sat   (w_mem_sat)
  );
endmodule

// File: tb/tb_dcache_port_arb.sv
// tb_dcache_port_arb: directed stimulus with a scoreboard of expected cache requests checked at each handshake
module tb_dcache_port_arb;
  logic        clk = 1'b0, clr = 1'b1;
  logic        mem_valid = 0, wb_valid = 0, wb_urgent = 0, c_ready = 0;
  logic [31:0] mem_addr = 0, wb_addr = 0, c_addr;
  logic [63:0] wb_data = 0, c_data;
  logic [1:0]  mem_rw = 0, mem_size = 0, wb_size = 0, c_rw, c_size;
  logic [6:0]  mem_ptcid = 0, wb_ptcid = 0, c_ptcid;
  logic        mem_accept, wb_accept, c_req_valid, c_req_is_wb, mem_stall;
  typedef struct packed {
    logic        wb;
    logic [31:0] addr;
    logic [63:0] data;
    logic [1:0]  rw;
    logic [1:0]  size;
    logic [6:0]  ptcid;
  } req_t;
  req_t q[$];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  dcache_port_arb dut (
    .clk(clk), .clr(clr),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_size(mem_size),
    .mem_ptcid(mem_ptcid), .mem_accept(mem_accept),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_size(wb_size),
    .wb_ptcid(wb_ptcid), .wb_urgent(wb_urgent), .wb_accept(wb_accept),
    .c_ready(c_ready), .c_req_valid(c_req_valid), .c_req_is_wb(c_req_is_wb),
    .c_addr(c_addr), .c_data(c_data), .c_rw(c_rw), .c_size(c_size), .c_ptcid(c_ptcid),
    .mem_stall(mem_stall)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic push_m(input logic [31:0] a, input logic [1:0] rw, input logic [1:0] sz, input logic [6:0] id);
    q.push_back('{1'b0, a, 64'h0, rw, sz, id});
  endtask
  task automatic push_w(input logic [31:0] a, input logic [63:0] d, input logic [1:0] sz, input logic [6:0] id);
    q.push_back('{1'b1, a, d, 2'b10, sz, id});
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (!clr && c_req_valid && c_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_underflow: got unexpected request addr %0h expected none", c_addr);
      end else begin
        req_t e;
        e = q.pop_front();
        chk("sb_is_wb", 64'(c_req_is_wb), 64'(e.wb));
        chk("sb_addr",  64'(c_addr),      64'(e.addr));
        chk("sb_data",  c_data,           e.data);
        chk("sb_rw",    64'(c_rw),        64'(e.rw));
        chk("sb_size",  64'(c_size),      64'(e.size));
        chk("sb_ptcid", 64'(c_ptcid),     64'(e.ptcid));
      end
    end
  initial begin
    // reset: outputs zero, accept suppressed even with a pending M request
    mem_valid = 1; mem_rw = 2'b01; mem_addr = 32'h0000_1234;
    @(negedge clk);
    chk("rst_valid",  64'(c_req_valid), 64'd0);
    chk("rst_accept", 64'(mem_accept),  64'd0);
    chk("rst_stall",  64'(mem_stall),   64'd0);
    chk("rst_addr",   64'(c_addr),      64'd0);
    nxt();
    clr = 0; mem_valid = 0; mem_rw = 0;
    // WB capture then clr while stalled
    wb_valid = 1; wb_addr = 32'h0700_0010; wb_data = 64'h1111_2222_3333_4444; wb_size = 2'b11; wb_ptcid = 7'h09;
    @(negedge clk);
    chk("clrwb_accept", 64'(wb_accept), 64'd1);
    nxt();
    wb_valid = 0;
    @(negedge clk);
    chk("clrwb_busy_valid", 64'(c_req_valid), 64'd1);
    chk("clrwb_busy_iswb",  64'(c_req_is_wb), 64'd1);
    #1 clr = 1;
    #1;
    chk("clr_valid", 64'(c_req_valid), 64'd0);
    chk("clr_iswb",  64'(c_req_is_wb), 64'd0);
    chk("clr_addr",  64'(c_addr),      64'd0);
    chk("clr_state", 64'(dut.r_state), 64'd0);
    chk("clr_wbcnt", 64'(dut.u_wb_ctr.cnt), 64'd0);
    nxt();
    clr = 0;
    @(negedge clk);
    chk("post_clr_idle", 64'(c_req_valid), 64'd0);
    nxt();
    // single M read with back-to-back second request
    c_ready = 1;
    mem_valid = 1; mem_addr = 32'h0500_0040; mem_rw = 2'b01; mem_size = 2'b10; mem_ptcid = 7'h05;
    push_m(32'h0500_0040, 2'b01, 2'b10, 7'h05);
    @(negedge clk);
    chk("m1_accept", 64'(mem_accept), 64'd1);
    chk("m1_stall",  64'(mem_stall),  64'd0);
    nxt();
    mem_addr = 32'h0500_0080; mem_rw = 2'b10; mem_size = 2'b11; mem_ptcid = 7'h06;
    push_m(32'h0500_0080, 2'b10, 2'b11, 7'h06);
    @(negedge clk);
    chk("m1_valid_n1", 64'(c_req_valid), 64'd1);
    chk("m1_addr_n1",  64'(c_addr),      64'h0500_0040);
    chk("m2_accept",   64'(mem_accept),  64'd1);
    nxt();
    mem_valid = 0;
    @(negedge clk);
    chk("m2_no_accept", 64'(mem_accept), 64'd0);
    nxt();
    // cache stall holds the M payload while WB waits
    c_ready = 0;
    mem_valid = 1; mem_addr = 32'h0A00_0100; mem_rw = 2'b11; mem_size = 2'b01; mem_ptcid = 7'h33;
    push_m(32'h0A00_0100, 2'b11, 2'b01, 7'h33);
    @(negedge clk);
    chk("st_m_accept", 64'(mem_accept), 64'd1);
    nxt();
    mem_valid = 0;
    wb_valid = 1; wb_addr = 32'h0B00_0200; wb_data = 64'hCAFE_F00D_0000_0001; wb_size = 2'b10; wb_ptcid = 7'h44;
    mem_addr = 32'hFFFF_FFFF; mem_rw = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("st_hold_valid", 64'(c_req_valid), 64'd1);
      chk("st_hold_addr",  64'(c_addr),      64'h0A00_0100);
      chk("st_hold_rw",    64'(c_rw),        64'(2'b11));
      chk("st_wb_accept",  64'(wb_accept),   64'd0);
      chk("st_wb_starve",  64'(dut.u_wb_ctr.cnt), 64'd0);
      nxt();
    end
    c_ready = 1;
    push_w(32'h0B00_0200, 64'hCAFE_F00D_0000_0001, 2'b10, 7'h44);
    @(negedge clk);
    chk("st_wb_accept_rdy", 64'(wb_accept), 64'd1);
    nxt();
    wb_valid = 0;
    @(negedge clk);
    nxt();
    // starvation: 6 M grants then WB is forced
    mem_valid = 1; mem_addr = 32'h1000_0000; mem_rw = 2'b01; mem_size = 2'b10; mem_ptcid = 7'h11;
    wb_valid = 1; wb_addr = 32'h2000_0000; wb_data = 64'hDEAD_BEEF_0123_4567; wb_size = 2'b11; wb_ptcid = 7'h22;
    for (int i = 0; i < 8; i++) begin
      if (i == 6) push_w(32'h2000_0000, 64'hDEAD_BEEF_0123_4567, 2'b11, 7'h22);
      else push_m(32'h1000_0000, 2'b01, 2'b10, 7'h11);
      @(negedge clk);
      chk("sv_mem_accept", 64'(mem_accept), 64'(i != 6));
      chk("sv_wb_accept",  64'(wb_accept),  64'(i == 6));
      if (i == 6) begin
        chk("sv_wb_starve_sat", 64'(dut.u_wb_ctr.cnt), 64'd6);
        chk("sv_mem_stall",     64'(mem_stall),        64'd1);
      end
      if (i == 7) chk("sv_wb_starve_clr", 64'(dut.u_wb_ctr.cnt), 64'd0);
      nxt();
    end
    mem_valid = 0; wb_valid = 0;
    @(negedge clk);
    nxt();
    // urgent WB beats M
    mem_valid = 1; mem_addr = 32'h3000_0008; mem_rw = 2'b10; mem_size = 2'b00; mem_ptcid = 7'h55;
    wb_valid = 1; wb_urgent = 1; wb_addr = 32'h4000_0010; wb_data = 64'h0123_4567_89AB_CDEF; wb_size = 2'b01; wb_ptcid = 7'h66;
    push_w(32'h4000_0010, 64'h0123_4567_89AB_CDEF, 2'b01, 7'h66);
    @(negedge clk);
    chk("ur_wb_accept",  64'(wb_accept),  64'd1);
    chk("ur_mem_accept", 64'(mem_accept), 64'd0);
    chk("ur_mem_stall",  64'(mem_stall),  64'd1);
    nxt();
    wb_valid = 0; wb_urgent = 0;
    push_m(32'h3000_0008, 2'b10, 2'b00, 7'h55);
    @(negedge clk);
    chk("ur_mem_starve", 64'(dut.u_mem_ctr.cnt), 64'd1);
    chk("ur_m_accept",   64'(mem_accept),        64'd1);
    nxt();
    mem_valid = 0;
    @(negedge clk);
    nxt();
    // null M request: mem_rw=00 is not a request
    mem_valid = 1; mem_rw = 2'b00; mem_addr = 32'h5000_0000;
    @(negedge clk);
    chk("null_accept", 64'(mem_accept),  64'd0);
    chk("null_stall",  64'(mem_stall),   64'd1);
    chk("null_valid",  64'(c_req_valid), 64'd0);
    nxt();
    @(negedge clk);
    chk("null_state", 64'(dut.r_state), 64'd0);
    chk("null_valid2", 64'(c_req_valid), 64'd0);
    nxt();
    mem_valid = 0;
    repeat (2) @(posedge clk);
    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
